// File: rtl/obi_mem_responder.sv
// rtl/obi_mem_responder.sv - constraining memory-side responder for one OBI request/response port
// Turns free random grant/valid/data into legal, in-order, bounded-latency handshakes and flags core errors.
module obi_mem_responder #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned MAX_GNT_WAIT    = 4,
  parameter int unsigned MAX_RVALID_WAIT = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   req_i,
  input  logic [ADDR_WIDTH-1:0]                  addr_i,
  input  logic                                   we_i,
  input  logic [DATA_WIDTH/8-1:0]                be_i,
  input  logic [DATA_WIDTH-1:0]                  wdata_i,
  output logic                                   gnt_o,
  output logic                                   rvalid_o,
  output logic [DATA_WIDTH-1:0]                  rdata_o,
  input  logic                                   rand_gnt_i,
  input  logic                                   rand_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                  rand_rdata_i,
  output logic [ADDR_WIDTH-1:0]                  rsp_addr_o,
  output logic                                   rsp_we_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   protocol_err_o
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned GW = (MAX_GNT_WAIT > 0) ? $clog2(MAX_GNT_WAIT + 1) : 1;
  localparam int unsigned RW = (MAX_RVALID_WAIT > 0) ? $clog2(MAX_RVALID_WAIT + 1) : 1;
  localparam int unsigned BW = DATA_WIDTH / 8;

  localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] PTR_LAST  = PW'(MAX_OUTSTANDING - 1);
  localparam logic [GW-1:0] GWAIT_MAX = GW'(MAX_GNT_WAIT);
  localparam logic [RW-1:0] RWAIT_MAX = RW'(MAX_RVALID_WAIT);

  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [GW-1:0]         gwait_q, gwait_d;
  logic [RW-1:0]         rwait_q, rwait_d;
  logic [ADDR_WIDTH-1:0] addr_mem_q [MAX_OUTSTANDING];
  logic                  we_mem_q   [MAX_OUTSTANDING];

  logic                  pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic                  req_we_q;
  logic [BW-1:0]         req_be_q;
  logic [DATA_WIDTH-1:0] req_wdata_q;
  logic                  err_q, err_d;

  logic                  gnt, rvalid, full, empty, viol;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic                  head_we;

  always_comb begin
    full      = (count_q == CNT_MAX);
    empty     = (count_q == '0);
    head_addr = addr_mem_q[rd_ptr_q];
    head_we   = we_mem_q[rd_ptr_q];

    // Full blocks even a forced grant; a pop only frees the slot next cycle.
    gnt    = rst_ni & req_i & ~full & (rand_gnt_i | (gwait_q == GWAIT_MAX));
    rvalid = rst_ni & ~empty & (rand_rvalid_i | (rwait_q == RWAIT_MAX));

    gnt_o          = gnt;
    rvalid_o       = rvalid;
    rdata_o        = (rvalid & ~head_we) ? rand_rdata_i : '0;
    rsp_addr_o     = (rst_ni & ~empty) ? head_addr : '0;
    rsp_we_o       = rst_ni & ~empty & head_we;
    outstanding_o  = rst_ni ? count_q : '0;
    protocol_err_o = err_q;

    count_d = count_q;
    if (gnt & ~rvalid) begin
      count_d = count_q + CW'(1);
    end else if (~gnt & rvalid) begin
      count_d = count_q - CW'(1);
    end

    wr_ptr_d = wr_ptr_q;
    if (gnt) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
    end
    rd_ptr_d = rd_ptr_q;
    if (rvalid) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
    end

    gwait_d = '0;
    if (req_i & ~gnt) begin
      gwait_d = (gwait_q == GWAIT_MAX) ? GWAIT_MAX : gwait_q + GW'(1);
    end
    rwait_d = '0;
    if (~empty & ~rvalid) begin
      rwait_d = (rwait_q == RWAIT_MAX) ? RWAIT_MAX : rwait_q + RW'(1);
    end

    // An ungranted request must be held stable until it is granted.
    viol = pend_q & (~req_i | (addr_i != req_addr_q) | (we_i != req_we_q) |
                     (be_i != req_be_q) | (req_we_q & (wdata_i != req_wdata_q)));
    pend_d = req_i & ~gnt;
    err_d  = err_q | viol;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      gwait_q     <= '0;
      rwait_q     <= '0;
      pend_q      <= 1'b0;
      req_addr_q  <= '0;
      req_we_q    <= 1'b0;
      req_be_q    <= '0;
      req_wdata_q <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        addr_mem_q[i] <= '0;
        we_mem_q[i]   <= 1'b0;
      end
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      gwait_q     <= gwait_d;
      rwait_q     <= rwait_d;
      pend_q      <= pend_d;
      req_addr_q  <= addr_i;
      req_we_q    <= we_i;
      req_be_q    <= be_i;
      req_wdata_q <= wdata_i;
      err_q       <= err_d;
      if (gnt) begin
        addr_mem_q[wr_ptr_q] <= addr_i;
        we_mem_q[wr_ptr_q]   <= we_i;
      end
    end
  end

endmodule

// File: tb/tb_obi_mem_responder.sv
// tb/tb_obi_mem_responder.sv - self-checking bench for obi_mem_responder
// Two instances (zero waits and waits of 4) share the core-side and random inputs.
module tb_obi_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rand_gnt;
  logic        rand_rv;
  logic [31:0] rand_rdata;

  logic        gnt_0, rv_0, rwe_0, err_0;
  logic [31:0] rdata_0, raddr_0;
  logic [1:0]  out_0;
  logic        gnt_4, rv_4, rwe_4, err_4;
  logic [31:0] rdata_4, raddr_4;
  logic [1:0]  out_4;

  int checks = 0;
  int failures = 0;

  obi_mem_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2),
    .MAX_GNT_WAIT(0), .MAX_RVALID_WAIT(0)
  ) u0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .gnt_o(gnt_0), .rvalid_o(rv_0), .rdata_o(rdata_0),
    .rand_gnt_i(rand_gnt), .rand_rvalid_i(rand_rv), .rand_rdata_i(rand_rdata),
    .rsp_addr_o(raddr_0), .rsp_we_o(rwe_0), .outstanding_o(out_0), .protocol_err_o(err_0)
  );

  obi_mem_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2),
    .MAX_GNT_WAIT(4), .MAX_RVALID_WAIT(4)
  ) u4 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .gnt_o(gnt_4), .rvalid_o(rv_4), .rdata_o(rdata_4),
    .rand_gnt_i(rand_gnt), .rand_rvalid_i(rand_rv), .rand_rdata_i(rand_rdata),
    .rsp_addr_o(raddr_4), .rsp_we_o(rwe_4), .outstanding_o(out_4), .protocol_err_o(err_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        e_gnt;
    logic        e_rv;
    logic [31:0] e_rdata;
    logic [31:0] e_raddr;
    logic        e_rwe;
    logic [1:0]  e_out;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    req      = 1'b0;
    rand_gnt = 1'b0;
    rand_rv  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Reference model state for the randomized phase (index 0: u0, 1: u4)
  int          gw_lim[2] = '{0, 4};
  int          rw_lim[2] = '{0, 4};
  int          m_gw[2], m_rw[2];
  bit          m_pend[2], m_err[2];
  logic [32:0] mq0[$], mq1[$];
  logic [31:0] p_addr, p_wdata;
  logic        p_we;
  logic [3:0]  p_be;

  initial begin
    logic [31:0] fa[3];
    int          gi;
    int          gcyc[3];
    logic [31:0] rq[$];
    int          rcyc[$];
    int          sz;
    logic [32:0] head;
    logic        eg, ev, viol;
    logic [31:0] erd;
    logic        a_gnt, a_rv, a_err, a_rwe;
    logic [31:0] a_rdata, a_raddr;
    logic [1:0]  a_out;

    vt[0] = '{1'b1, 32'h1A000080, 1'b0, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0};
    vt[1] = '{1'b0, 32'h0, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, 32'hDEADBEEF, 32'h1A000080, 1'b0, 2'd1};
    vt[2] = '{1'b0, 32'h0, 1'b0, 32'h0, 32'h11111111, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0};
    vt[3] = '{1'b1, 32'h40, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0};
    vt[4] = '{1'b1, 32'h44, 1'b1, 32'h12345678, 32'h55AA55AA, 1'b1, 1'b1, 32'h55AA55AA, 32'h40, 1'b0, 2'd1};
    vt[5] = '{1'b0, 32'h0, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1, 32'h0, 32'h44, 1'b1, 2'd1};
    vt[6] = '{1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0};

    rst_n = 1'b0; req = 1'b0; addr = '0; we = 1'b0; be = 4'hF; wdata = '0;
    rand_gnt = 1'b0; rand_rv = 1'b0; rand_rdata = '0;

    // Outputs stay quiet during reset even with everything requested
    @(negedge clk);
    req = 1'b1; rand_gnt = 1'b1; rand_rv = 1'b1; rand_rdata = 32'hFFFFFFFF;
    #1;
    chk("rst_gnt", gnt_0, 1'b0);
    chk("rst_rvalid", rv_0, 1'b0);
    chk("rst_outstanding", out_0, 2'd0);
    chk("rst_rdata", rdata_0, 32'h0);
    @(negedge clk);
    #1;
    chk("rst_err", err_0, 1'b0);
    chk("rst_gnt4", gnt_4, 1'b0);

    // Table: zero-wait instance, immediate response, write response, push+pop
    rst_n = 1'b1; rand_gnt = 1'b1; rand_rv = 1'b1;
    for (int r = 0; r < 7; r++) begin
      req = vt[r].req; addr = vt[r].addr; we = vt[r].we; wdata = vt[r].wdata;
      rand_rdata = vt[r].rdata;
      #1;
      chk($sformatf("vec%0d_gnt", r), gnt_0, vt[r].e_gnt);
      chk($sformatf("vec%0d_rvalid", r), rv_0, vt[r].e_rv);
      chk($sformatf("vec%0d_rdata", r), rdata_0, vt[r].e_rdata);
      chk($sformatf("vec%0d_outstanding", r), out_0, vt[r].e_out);
      if (vt[r].e_rv) begin
        chk($sformatf("vec%0d_rsp_addr", r), raddr_0, vt[r].e_raddr);
        chk($sformatf("vec%0d_rsp_we", r), rwe_0, vt[r].e_rwe);
      end
      @(negedge clk);
    end
    chk("vec_err", err_0, 1'b0);

    // Forced grant and forced response on the wait-4 instance
    do_reset();
    we = 1'b0; rand_rdata = 32'h0;
    for (int c = 0; c <= 10; c++) begin
      req  = (c <= 4) || (c >= 6);
      addr = (c <= 4) ? 32'h300 : 32'h304;
      #1;
      chk($sformatf("force_c%0d_gnt", c), gnt_4, (c == 4) || (c == 10));
      chk($sformatf("force_c%0d_rvalid", c), rv_4, c == 9);
      if (c == 9) chk("force_rsp_addr", raddr_4, 32'h300);
      @(negedge clk);
    end

    // Full FIFO: A, B granted, C held until a forced rvalid frees a slot
    do_reset();
    fa[0] = 32'h100; fa[1] = 32'h104; fa[2] = 32'h108;
    gi = 0; gcyc[0] = -1; gcyc[1] = -1; gcyc[2] = -1;
    rand_gnt = 1'b1; rand_rv = 1'b0; we = 1'b0;
    for (int c = 0; c < 30; c++) begin
      req  = (gi < 3);
      addr = (gi < 3) ? fa[gi] : 32'h0;
      #1;
      if (c == 2) begin
        chk("full_c_held_gnt", gnt_4, 1'b0);
        chk("full_outstanding", out_4, 2'd2);
      end
      if (gnt_4 && gi < 3) begin
        gcyc[gi] = c;
        gi++;
      end
      if (rv_4) begin
        rq.push_back(raddr_4);
        rcyc.push_back(c);
      end
      @(negedge clk);
    end
    chk("full_grants", gi, 3);
    chk("full_c_grant_cycle", gcyc[2], 6);
    chk("full_rsp_count", rq.size(), 3);
    if (rq.size() == 3) begin
      chk("full_rsp0_addr", rq[0], 32'h100);
      chk("full_rsp1_addr", rq[1], 32'h104);
      chk("full_rsp2_addr", rq[2], 32'h108);
      chk("full_rsp0_cycle", rcyc[0], 5);
      chk("full_rsp1_cycle", rcyc[1], 10);
      chk("full_rsp2_cycle", rcyc[2], 15);
    end
    chk("full_err", err_4, 1'b0);

    // Protocol violation, sticky flag, then reset with two outstanding
    do_reset();
    for (int c = 0; c <= 17; c++) begin
      rst_n    = (c != 12);
      rand_gnt = (c >= 2);
      rand_rv  = (c >= 3 && c <= 8) || (c >= 12);
      req      = (c <= 2) || (c == 9) || (c == 10) || (c == 12);
      addr     = (c == 0) ? 32'h200 : (c <= 2) ? 32'h204 : (c == 9) ? 32'h400 : 32'h404;
      #1;
      if (c == 1) chk("viol_err_t1", err_4, 1'b0);
      if (c == 2) chk("viol_err_t2", err_4, 1'b1);
      if (c == 8) chk("viol_err_sticky", err_4, 1'b1);
      if (c == 11) chk("prerst_outstanding", out_4, 2'd2);
      if (c == 12) begin
        chk("inrst_gnt", gnt_4, 1'b0);
        chk("inrst_rvalid", rv_4, 1'b0);
        chk("inrst_outstanding", out_4, 2'd0);
      end
      if (c == 13) begin
        chk("postrst_outstanding", out_4, 2'd0);
        chk("postrst_err", err_4, 1'b0);
      end
      if (c >= 13) chk($sformatf("postrst_c%0d_rvalid", c), rv_4, 1'b0);
      @(negedge clk);
    end

    // Randomized traffic against the queue-based reference model
    do_reset();
    for (int k = 0; k < 2; k++) begin
      m_gw[k] = 0; m_rw[k] = 0; m_pend[k] = 0; m_err[k] = 0;
    end
    mq0.delete(); mq1.delete();
    p_addr = '0; p_we = 1'b0; p_be = '0; p_wdata = '0;
    for (int c = 0; c < 1500; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if (!((m_pend[0] || m_pend[1]) && $urandom_range(0, 39) != 0)) begin
        req   = ($urandom_range(0, 2) != 0);
        addr  = $urandom & 32'hFFFF_FFFC;
        we    = $urandom_range(0, 1) == 1;
        be    = 4'($urandom);
        wdata = $urandom;
      end
      rand_gnt   = ($urandom_range(0, 2) == 0);
      rand_rv    = ($urandom_range(0, 2) == 0);
      rand_rdata = $urandom;
      #1;
      for (int k = 0; k < 2; k++) begin
        a_gnt   = (k == 0) ? gnt_0 : gnt_4;
        a_rv    = (k == 0) ? rv_0 : rv_4;
        a_rdata = (k == 0) ? rdata_0 : rdata_4;
        a_out   = (k == 0) ? out_0 : out_4;
        a_err   = (k == 0) ? err_0 : err_4;
        a_raddr = (k == 0) ? raddr_0 : raddr_4;
        a_rwe   = (k == 0) ? rwe_0 : rwe_4;
        sz = (k == 0) ? mq0.size() : mq1.size();
        head = '0;
        if (sz != 0) head = (k == 0) ? mq0[0] : mq1[0];
        if (!rst_n) begin
          chk($sformatf("rand%0d_k%0d_inrst", c, k), {a_gnt, a_rv, a_rdata, a_out}, 35'h0);
          m_gw[k] = 0; m_rw[k] = 0; m_pend[k] = 0; m_err[k] = 0;
          if (k == 0) mq0.delete(); else mq1.delete();
        end else begin
          eg  = req && (sz < 2) && (rand_gnt || m_gw[k] == gw_lim[k]);
          ev  = (sz != 0) && (rand_rv || m_rw[k] == rw_lim[k]);
          erd = (ev && !head[32]) ? rand_rdata : 32'h0;
          chk($sformatf("rand%0d_k%0d_gnt_rv_rdata_out_err", c, k),
              {a_gnt, a_rv, a_rdata, a_out, a_err}, {eg, ev, erd, 2'(sz), m_err[k]});
          if (ev) chk($sformatf("rand%0d_k%0d_rsp", c, k), {a_rwe, a_raddr}, head);
          viol = m_pend[k] && (!req || addr != p_addr || we != p_we || be != p_be ||
                               (p_we && wdata != p_wdata));
          if (viol) m_err[k] = 1'b1;
          m_pend[k] = req && !eg;
          m_gw[k] = (req && !eg) ? ((m_gw[k] < gw_lim[k]) ? m_gw[k] + 1 : gw_lim[k]) : 0;
          m_rw[k] = (sz != 0 && !ev) ? ((m_rw[k] < rw_lim[k]) ? m_rw[k] + 1 : rw_lim[k]) : 0;
          if (k == 0) begin
            if (ev) void'(mq0.pop_front());
            if (eg) mq0.push_back({we, addr});
          end else begin
            if (ev) void'(mq1.pop_front());
            if (eg) mq1.push_back({we, addr});
          end
        end
      end
      p_addr = addr; p_we = we; p_be = be; p_wdata = wdata;
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
